// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared types and sizing for the multiply sequencer
package mult_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        SIGN
    } state_t;

    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/mult_shift_add_dp.sv
// rtl/mult_shift_add_dp.sv - shift-add multiply datapath with sign fix-up and HI/LO commit
module mult_shift_add_dp #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic             commit,
    input  logic             sign,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic               neg_q, neg_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] product;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;

    always_comb begin
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        neg_d    = neg_q;
        hi_d     = hi_q;
        lo_d     = lo_q;

        // Magnitudes stay WIDTH-bit unsigned, so the most negative value needs no extra bit
        abs_a   = (sign & op_a[WIDTH-1]) ? -op_a : op_a;
        abs_b   = (sign & op_b[WIDTH-1]) ? -op_b : op_b;
        sum     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (mplier_q[0] ? {1'b0, mcand_q} : '0);
        product = neg_q ? -acc_q : acc_q;

        if (load) begin
            mcand_d  = abs_a;
            mplier_d = abs_b;
            neg_d    = sign & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
            acc_d    = '0;
        end
        if (step) begin
            acc_d    = {sum, acc_q[WIDTH-1:1]};
            mplier_d = mplier_q >> 1;
        end
        if (commit) begin
            {hi_d, lo_d} = product;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            neg_q    <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            neg_q    <= neg_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    assign hi = hi_q;
    assign lo = lo_q;

endmodule

// File: rtl/mult_sequencer.sv
// rtl/mult_sequencer.sv - MULT/MULTU sequencer FSM with pipeline stall and HI/LO outputs
module mult_sequencer
    import mult_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_mult,
    input  logic             mult_sign,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             read_hilo,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int            CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          done_q, done_d;
    logic          load, step, commit;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        load    = 1'b0;
        step    = 1'b0;
        commit  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_mult) begin
                    load    = 1'b1;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                step  = 1'b1;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d = SIGN;
                end
            end
            SIGN: begin
                commit  = 1'b1;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    // A start while busy is dropped; the pipeline stalls and re-presents it
    assign busy  = (state_q != IDLE);
    assign stall = busy & (read_hilo | start_mult);
    assign done  = done_q;

    mult_shift_add_dp #(
        .WIDTH(WIDTH)
    ) u_dp (
        .clk    (clk),
        .rst    (rst),
        .load   (load),
        .step   (step),
        .commit (commit),
        .sign   (mult_sign),
        .op_a   (op_a),
        .op_b   (op_b),
        .hi     (hi),
        .lo     (lo)
    );

endmodule

// File: tb/tb_mult_sequencer.sv
// tb/tb_mult_sequencer.sv - randomized self-checking bench for mult_sequencer
module tb_mult_sequencer;

    logic        clk;
    logic        rst;
    logic        start_mult;
    logic        mult_sign;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        read_hilo;
    logic        busy;
    logic        stall;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int          n_vectors;
    int          n_miscompares;
    logic [63:0] model_p;

    mult_sequencer #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_mult (start_mult),
        .mult_sign  (mult_sign),
        .op_a       (op_a),
        .op_b       (op_b),
        .read_hilo  (read_hilo),
        .busy       (busy),
        .stall      (stall),
        .done       (done),
        .hi         (hi),
        .lo         (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vectors++;
        if (got !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input logic s);
        longint sa;
        longint sb;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return 64'(sa * sb);
        end
        return {32'b0, a} * {32'b0, b};
    endfunction

    // Follows one multiply from the cycle after its accepting edge through the done cycle
    task automatic track(input logic [63:0] old_p, input logic [63:0] new_p, input bit rh,
                         input bit re, input logic [31:0] a2, input logic [31:0] b2, input logic s2);
        for (int c = 1; c <= 33; c++) begin
            @(posedge clk);
            #1;
            if (rh && c >= 2) read_hilo = 1'b1;
            if (re && c >= 5) begin
                start_mult = 1'b1;
                op_a       = a2;
                op_b       = b2;
                mult_sign  = s2;
            end
            #1;
            check("busy", 64'(busy), 64'(c < 33));
            check("stall", 64'(stall), 64'((c < 33) && (read_hilo || start_mult)));
            check("done", 64'(done), 64'(c == 33));
            check("hilo", {hi, lo}, (c < 33) ? old_p : new_p);
        end
    endtask

    task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input logic s, input bit rh,
                           input bit re, input logic [31:0] a2, input logic [31:0] b2, input logic s2);
        logic [63:0] p1;
        logic [63:0] p2;
        p1         = ref_mul(a, b, s);
        op_a       = a;
        op_b       = b;
        mult_sign  = s;
        start_mult = 1'b1;
        @(posedge clk);
        #1;
        start_mult = 1'b0;
        op_a       = 32'($urandom);
        op_b       = 32'($urandom);
        track(model_p, p1, rh, re, a2, b2, s2);
        model_p   = p1;
        read_hilo = 1'b0;
        if (re) begin
            p2 = ref_mul(a2, b2, s2);
            @(posedge clk);
            #1;
            start_mult = 1'b0;
            track(model_p, p2, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
            model_p = p2;
        end
        @(posedge clk);
        #2;
        check("done_once", 64'(done), 64'h0);
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [63:0] p;
    } dvec_t;

    dvec_t dirs[5];
    logic [31:0] corners[6];

    initial begin
        n_vectors     = 0;
        n_miscompares = 0;
        model_p       = 64'h0;
        rst           = 1'b1;
        start_mult    = 1'b0;
        mult_sign     = 1'b0;
        op_a          = 32'h0;
        op_b          = 32'h0;
        read_hilo     = 1'b0;

        dirs[0] = '{32'h00000003, 32'h00000005, 1'b0, 64'h00000000_0000000F};
        dirs[1] = '{32'hFFFFFFFD, 32'h00000007, 1'b1, 64'hFFFFFFFF_FFFFFFEB};
        dirs[2] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE_00000001};
        dirs[3] = '{32'h80000000, 32'h80000000, 1'b1, 64'h40000000_00000000};
        dirs[4] = '{32'h80000000, 32'h00000001, 1'b1, 64'hFFFFFFFF_80000000};
        corners = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h80000001};

        repeat (3) @(posedge clk);
        #1;
        read_hilo = 1'b1;
        #1;
        check("rst_busy", 64'(busy), 64'h0);
        check("rst_stall", 64'(stall), 64'h0);
        check("rst_done", 64'(done), 64'h0);
        check("rst_hilo", {hi, lo}, 64'h0);
        read_hilo = 1'b0;
        rst       = 1'b0;

        // Directed products, each also anchored to a hand-computed constant
        foreach (dirs[i]) begin
            run_mul(dirs[i].a, dirs[i].b, dirs[i].s, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
            check("dir_const", {hi, lo}, dirs[i].p);
        end

        // MFHI/MFLO held in decode from cycle 2
        run_mul(32'h12345678, 32'h9ABCDEF0, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);

        // Start re-presented during RUN, accepted after the done cycle
        run_mul(32'h00000011, 32'hFFFFFFF0, 1'b1, 1'b0, 1'b1, 32'hDEADBEEF, 32'h00010001, 1'b0);

        // Start and read together in IDLE: no stall
        start_mult = 1'b1;
        read_hilo  = 1'b1;
        #1;
        check("idle_no_stall", 64'(stall), 64'h0);
        start_mult = 1'b0;
        read_hilo  = 1'b0;

        for (int i = 0; i < 16; i++) begin
            logic [31:0] a;
            logic [31:0] b;
            case ($urandom_range(0, 2))
                0: a = 32'($urandom);
                1: a = 32'($urandom_range(0, 255));
                default: a = corners[$urandom_range(0, 5)];
            endcase
            case ($urandom_range(0, 2))
                0: b = 32'($urandom);
                1: b = 32'($urandom_range(0, 255));
                default: b = corners[$urandom_range(0, 5)];
            endcase
            run_mul(a, b, 1'($urandom), 1'($urandom), 1'b0, 32'h0, 32'h0, 1'b0);
        end

        // Reset mid-RUN after a prior result of hi=1, lo=2
        run_mul(32'h00000002, 32'h80000001, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        check("prior_result", {hi, lo}, 64'h00000001_00000002);
        op_a       = 32'd5;
        op_b       = 32'd7;
        mult_sign  = 1'b0;
        start_mult = 1'b1;
        @(posedge clk);
        #1;
        start_mult = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("midrst_busy", 64'(busy), 64'h0);
        check("midrst_hilo", {hi, lo}, 64'h0);
        model_p = 64'h0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #2;
            check("midrst_no_done", 64'(done), 64'h0);
        end
        run_mul(32'd2, 32'd2, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        check("fresh_lo", {32'h0, lo}, 64'h4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule

// File: doc/mult_sequencer.md
# mult_sequencer

Multi-cycle multiply sequencer for the pipeline's MULT/MULTU path. It accepts `start_mult`/`mult_sign` from the control unit with the two register operands, and runs a radix-2 shift-add multiply over WIDTH cycles. It applies a sign fix-up and commits the 2·WIDTH-bit product to the HI/LO registers. While the multiply is in flight it raises `stall` to hold the pipeline whenever a following instruction needs HI/LO or the multiplier.

## Interface
Parameters:
- `WIDTH`, 32: operand width; HI and LO are each WIDTH bits.

Ports:
- `clk` in 1: single clock; all state changes on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start_mult` in 1: MULT/MULTU issued this cycle (from control unit).
- `mult_sign` in 1: 1 = signed (MULT), 0 = unsigned (MULTU); sampled with `start_mult`.
- `op_a` in WIDTH: rs operand.
- `op_b` in WIDTH: rt operand.
- `read_hilo` in 1: MFHI or MFLO is in decode this cycle (control unit `out_select` = HI/LO).
- `busy` out 1: multiply in progress (state ≠ IDLE).
- `stall` out 1: pipeline hold request.
- `done` out 1: one-cycle pulse when HI/LO are committed.
- `hi` out WIDTH: upper product half.
- `lo` out WIDTH: lower product half.

## Operation
- FSM states: IDLE, RUN, SIGN.
- IDLE → RUN on a rising edge with `start_mult`=1. The edge captures:
  - |op_a| and |op_b| when `mult_sign`=1; raw values when `mult_sign`=0.
  - `neg` = `mult_sign` & (op_a[MSB] ^ op_b[MSB]).
  - Clears the 2·WIDTH accumulator and the iteration counter.
- Magnitudes are WIDTH-bit unsigned, so −2^(WIDTH−1) maps to 2^(WIDTH−1) without overflow.
- RUN: each cycle examines multiplier bit 0.
  - If it is 1, add the multiplicand into the upper half of the accumulator with carry out retained (WIDTH+1-bit add).
  - Then shift the accumulator right by 1.
  - The counter goes 0..WIDTH−1. RUN → SIGN after the iteration with counter = WIDTH−1.
- SIGN: product = `neg` ? two's complement of the accumulator : accumulator.
  - Commit {`hi`,`lo`} ← product and pulse `done`.
  - SIGN → IDLE unconditionally.
- `hi`/`lo` change only at SIGN commit or reset. During RUN they hold the previous result.
- `stall` = `busy` & (`read_hilo` | `start_mult`), combinational.
- A `start_mult` while busy is not accepted and not queued. The pipeline re-presents it, and it is accepted on the first edge with state = IDLE.
- `start_mult` and `read_hilo` together in IDLE: no stall. The read sees the old HI/LO and the multiply starts.
- Reset at any time (including mid-RUN):
  - state → IDLE; counter, accumulator and `neg` → 0.
  - `hi` = `lo` = 0; `busy` = `stall` = `done` = 0.
  - The in-flight multiply is discarded.

## Timing
- Edge E0 samples `start_mult`. `busy`=1 from E0 to E(WIDTH+1).
- `hi`/`lo` hold the new result after edge E(WIDTH+1). `done`=1 in the cycle following that edge. `busy`=0 in that same cycle.
- Total latency is WIDTH+1 edges: WIDTH RUN iterations plus one SIGN cycle. This is 33 edges for WIDTH=32.
- An MFHI held in decode sees `stall` drop in the `done` cycle and reads the new value that cycle.
- Back-to-back MULT: the second is accepted at the edge that ends the `done` cycle.
- Output reset values: `busy`=0, `stall`=0, `done`=0, `hi`=0, `lo`=0.

## Structure
- Shared package `mult_pkg`:
  - State enum {IDLE, RUN, SIGN}.
  - Default `WIDTH` = 32.
  - Iteration counter width $clog2(WIDTH).
- One sub-module `mult_shift_add_dp`: accumulator, multiplicand register, WIDTH+1 adder and shifter, final negate.
  - Driven by `load`, `step`, `commit` strobes from the FSM in `mult_sequencer`.
  - Contains no FSM.

## Test plan
- Unsigned 3×5 (`mult_sign`=0) → after 33 edges `hi`=0x00000000, `lo`=0x0000000F, `done` pulses exactly once; `hi`/`lo` unchanged during RUN.
- Signed −3×7 (0xFFFFFFFD, 0x00000007) → `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB. Unsigned 0xFFFFFFFF×0xFFFFFFFF → `hi`=0xFFFFFFFE, `lo`=0x00000001.
- Signed 0x80000000×0x80000000 → `hi`=0x40000000, `lo`=0x00000000. Signed 0x80000000×0x00000001 → `hi`=0xFFFFFFFF, `lo`=0x80000000.
- `read_hilo` held high from cycle 2 after start → `stall`=1 through the last SIGN cycle, 0 in the `done` cycle, with `lo` already new.
- `start_mult` reasserted at cycle 5 of RUN with new operands → `stall`=1, first result unaffected. Second multiply accepted at the edge ending the `done` cycle, and its result appears 33 edges later.
- `rst` pulsed at RUN iteration 10 after a prior result 0x1/0x2 → next cycle `busy`=0, `hi`=`lo`=0, `done` never pulses. A fresh 2×2 then yields `lo`=4.
